// File: rtl/envelope_pkg.sv
// Shared widths, per-channel action encoding and level helpers for envelope_bank.
package envelope_pkg;

   localparam int ENV_VOL_W = 4;
   localparam int ENV_DIV_W = 4;

   typedef enum logic [1:0] {
      ACT_IDLE,
      ACT_RESTART,
      ACT_STEP,
      ACT_COUNT
   } env_action_e;

   // Terminal level for a w-bit decay counter.
   function automatic int unsigned env_max(input int unsigned w);
      return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
   endfunction

   // Keeps the low w bits of v; the caller's cast picks the final width.
   function automatic logic [31:0] env_resize(input logic [31:0] v, input int unsigned w);
      return (w >= 32) ? v : (v & ((32'd1 << w) - 32'd1));
   endfunction

endpackage

// File: rtl/envelope_channel.sv
// One envelope channel: restart flag, period divider, decay level and expiry.
// ENVELOPE_ATTACK_EN adds an attack input that makes the level count upwards.
module envelope_channel
   import envelope_pkg::*;
#(
   parameter int VOL_W = ENV_VOL_W,
   parameter int DIV_W = ENV_DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             qtick,
   input  logic             start,
   input  logic             loop,
   input  logic             const_vol,
`ifdef ENVELOPE_ATTACK_EN
   input  logic             attack,
`endif
   input  logic [DIV_W-1:0] period,
   output logic [VOL_W-1:0] volume,
   output logic             expired
);

   localparam logic [VOL_W-1:0] MAX = VOL_W'(env_max(VOL_W));

   logic             up;
   logic             start_flag;
   logic             start_flag_nxt;
   logic [DIV_W-1:0] divider;
   logic [DIV_W-1:0] divider_nxt;
   logic [VOL_W-1:0] decay;
   logic [VOL_W-1:0] decay_nxt;
   logic             expired_nxt;
   logic             at_end;
   env_action_e      action;

`ifdef ENVELOPE_ATTACK_EN
   assign up = attack;
`else
   assign up = 1'b0;
`endif

   always_comb begin
      at_end = up ? (decay == MAX) : (decay == '0);
      action = ACT_IDLE;
      if (qtick) begin
         if (start_flag || start) action = ACT_RESTART;
         else if (divider == '0)  action = ACT_STEP;
         else                     action = ACT_COUNT;
      end
   end

   always_comb begin
      start_flag_nxt = start_flag | start;
      divider_nxt    = divider;
      decay_nxt      = decay;
      expired_nxt    = expired;
      unique case (action)
         ACT_RESTART: begin
            start_flag_nxt = 1'b0;
            divider_nxt    = period;
            decay_nxt      = up ? '0 : MAX;
            expired_nxt    = 1'b0;
         end
         ACT_STEP: begin
            divider_nxt = period;
            if (!at_end)   decay_nxt = up ? decay + 1'b1 : decay - 1'b1;
            else if (loop) decay_nxt = up ? '0 : MAX;
            else           expired_nxt = 1'b1;
            // A looping channel is never expired after a reload.
            if (loop) expired_nxt = 1'b0;
         end
         ACT_COUNT: divider_nxt = divider - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_flag <= 1'b0;
         divider    <= '0;
         decay      <= '0;
         expired    <= 1'b0;
      end else begin
         start_flag <= start_flag_nxt;
         divider    <= divider_nxt;
         decay      <= decay_nxt;
         expired    <= expired_nxt;
      end
   end

   // Constant volume reuses the period field; decay keeps running underneath.
   assign volume = const_vol ? VOL_W'(env_resize(32'(period), DIV_W)) : decay;

endmodule

// File: rtl/envelope_bank.sv
// NCH independent volume envelopes advanced by a shared quarter-frame tick.
// ENVELOPE_ATTACK_EN adds a per-channel attack input (count-up envelopes).
module envelope_bank
   import envelope_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int VOL_W = ENV_VOL_W,
   parameter int DIV_W = ENV_DIV_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 qtick,
   input  logic [NCH-1:0]       start,
   input  logic [NCH-1:0]       loop,
   input  logic [NCH-1:0]       constVol,
`ifdef ENVELOPE_ATTACK_EN
   input  logic [NCH-1:0]       attack,
`endif
   input  logic [NCH*DIV_W-1:0] period,
   output logic [NCH*VOL_W-1:0] volume,
   output logic [NCH-1:0]       expired
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      envelope_channel #(
         .VOL_W(VOL_W),
         .DIV_W(DIV_W)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .qtick    (qtick),
         .start    (start[i]),
         .loop     (loop[i]),
         .const_vol(constVol[i]),
`ifdef ENVELOPE_ATTACK_EN
         .attack   (attack[i]),
`endif
         .period   (period[i*DIV_W +: DIV_W]),
         .volume   (volume[i*VOL_W +: VOL_W]),
         .expired  (expired[i])
      );
   end

endmodule

// File: tb/tb_envelope_bank.sv
// Self-checking bench for envelope_bank: directed scenarios plus random traffic
// compared against a per-channel integer model of the envelope rules.
module tb_envelope_bank;

   localparam int NCH  = 4;
   localparam int MAXV = 15;

   logic        clk;
   logic        rstn;
   logic        qt;
   logic [3:0]  st;
   logic [3:0]  lp;
   logic [3:0]  cv;
   logic [3:0]  at;
   logic [15:0] per;
   logic [15:0] volume;
   logic [3:0]  expired;

   int n_pass  = 0;
   int n_total = 0;

   // model state per channel
   bit m_pend[NCH];
   int m_div[NCH];
   int m_dec[NCH];
   bit m_exp[NCH];

   envelope_bank #(.NCH(4), .VOL_W(4), .DIV_W(4)) dut (
      .clk     (clk),
      .rst_n   (rstn),
      .qtick   (qt),
      .start   (st),
      .loop    (lp),
      .constVol(cv),
`ifdef ENVELOPE_ATTACK_EN
      .attack  (at),
`endif
      .period  (per),
      .volume  (volume),
      .expired (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply the envelope rules to the inputs about to be sampled at the next edge.
   task automatic model_step();
      for (int c = 0; c < NCH; c++) begin
         int p;
         bit up;
         bit fin;
         p  = int'(per[c*4 +: 4]);
`ifdef ENVELOPE_ATTACK_EN
         up = at[c];
`else
         up = 1'b0;
`endif
         if (!rstn) begin
            m_pend[c] = 0; m_div[c] = 0; m_dec[c] = 0; m_exp[c] = 0;
         end else if (qt) begin
            if (m_pend[c] || st[c]) begin
               m_pend[c] = 0;
               m_dec[c]  = up ? 0 : MAXV;
               m_div[c]  = p;
               m_exp[c]  = 0;
            end else if (m_div[c] == 0) begin
               m_div[c] = p;
               fin = up ? (m_dec[c] == MAXV) : (m_dec[c] == 0);
               if (!fin)       m_dec[c] = up ? m_dec[c] + 1 : m_dec[c] - 1;
               else if (lp[c]) m_dec[c] = up ? 0 : MAXV;
               else            m_exp[c] = 1;
               if (lp[c]) m_exp[c] = 0;
            end else begin
               m_div[c] = m_div[c] - 1;
            end
         end else if (st[c]) begin
            m_pend[c] = 1;
         end
      end
   endtask

   function automatic logic [3:0] exp_vol(input int c);
      if (cv[c]) return per[c*4 +: 4];
      return 4'(m_dec[c]);
   endfunction

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 0; st = 0; qt = 0; lp = 0; cv = 0; at = 0;
      step();
      rstn = 1;
   endtask

   task automatic test_reset();
      rstn = 0; st = 4'hF; qt = 1; cv = 0; lp = 0; at = 0;
      per = 16'($urandom);
      step();
      n_total++;
      if (volume !== 16'h0 || expired !== 4'h0)
         $display("FAIL reset_state vol=%h exp=%b required vol=0000 exp=0000", volume, expired);
      else n_pass++;
      cv = 4'hF; #1;
      n_total++;
      if (volume !== per)
         $display("FAIL reset_constvol vol=%h required %h", volume, per);
      else n_pass++;
      cv = 0; rstn = 1; st = 0; qt = 0;
   endtask

   task automatic test_oneshot();
      do_reset();
      per = 16'h0003; lp = 0;
      st = 4'b0001; step(); st = 0;
      for (int n = 1; n <= 70; n++) begin
         qt = 1; step(); qt = 0;
         if (n == 1 || n == 5 || n == 61 || n == 65 || n == 70) begin
            int req;
            req = (n == 1) ? 15 : (n == 5) ? 14 : 0;
            n_total++;
            if (volume[3:0] !== 4'(req))
               $display("FAIL oneshot_vol q%0d got %0d required %0d", n, volume[3:0], req);
            else n_pass++;
         end
         if (n == 64 || n == 65) begin
            n_total++;
            if (expired[0] !== (n == 65))
               $display("FAIL oneshot_expired q%0d got %b required %b", n, expired[0], (n == 65));
            else n_pass++;
         end
         for (int c = 0; c < NCH; c++) begin
            n_total++;
            if (volume[c*4 +: 4] !== exp_vol(c) || expired[c] !== m_exp[c])
               $display("FAIL oneshot_model ch%0d q%0d vol=%0d exp=%b required vol=%0d exp=%b",
                        c, n, volume[c*4 +: 4], expired[c], exp_vol(c), m_exp[c]);
            else n_pass++;
         end
         step();
      end
   endtask

   task automatic test_loop();
      int bad_exp;
      do_reset();
      per = 16'h0003; lp = 4'b0001;
      st = 4'b0001; step(); st = 0;
      bad_exp = 0;
      for (int n = 1; n <= 70; n++) begin
         qt = 1; step(); qt = 0;
         if (expired[0] !== 1'b0) bad_exp++;
         if (n == 61 || n == 65 || n == 69) begin
            int req;
            req = (n == 61) ? 0 : (n == 65) ? 15 : 14;
            n_total++;
            if (volume[3:0] !== 4'(req))
               $display("FAIL loop_vol q%0d got %0d required %0d", n, volume[3:0], req);
            else n_pass++;
         end
      end
      n_total++;
      if (bad_exp != 0)
         $display("FAIL loop_expired asserted on %0d qticks required 0", bad_exp);
      else n_pass++;
   endtask

   task automatic test_const_vol();
      do_reset();
      per = 16'h9000; lp = 0; cv = 4'b1000; #1;
      n_total++;
      if (volume[15:12] !== 4'd9)
         $display("FAIL constvol_immediate got %0d required 9", volume[15:12]);
      else n_pass++;
      st = 4'b1000; qt = 1; step(); st = 0;
      for (int n = 2; n <= 11; n++) begin
         qt = 1; step(); qt = 0;
      end
      n_total++;
      if (volume[15:12] !== 4'd9)
         $display("FAIL constvol_held got %0d required 9", volume[15:12]);
      else n_pass++;
      cv = 0; #1;
      n_total++;
      if (volume[15:12] !== 4'd14)
         $display("FAIL constvol_underlying got %0d required 14", volume[15:12]);
      else n_pass++;
   endtask

   task automatic test_same_cycle();
      do_reset();
      per = 16'h0520; lp = 0;
      st = 4'b0010; qt = 1; step();
      n_total++;
      if (volume[7:4] !== 4'd15 || volume[11:8] !== 4'd0)
         $display("FAIL samecycle_restart ch1=%0d ch2=%0d required 15 and 0", volume[7:4], volume[11:8]);
      else n_pass++;
      st = 4'b0100; qt = 0; step();
      st = 0; step(); step();
      st = 4'b0100; step(); st = 0; step();
      n_total++;
      if (volume[11:8] !== 4'd0)
         $display("FAIL pending_no_qtick ch2=%0d required 0", volume[11:8]);
      else n_pass++;
      qt = 1; step(); qt = 0;
      n_total++;
      if (volume[11:8] !== 4'd15)
         $display("FAIL pending_restart ch2=%0d required 15", volume[11:8]);
      else n_pass++;
      for (int n = 0; n < 6; n++) begin
         qt = 1; step(); qt = 0; step();
      end
      n_total++;
      if (volume[11:8] !== 4'd14 || volume[7:4] !== 4'd13)
         $display("FAIL merged_starts ch2=%0d ch1=%0d required 14 and 13", volume[11:8], volume[7:4]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      per = 16'h0000; lp = 0;
      st = 4'b0001; qt = 1; step(); st = 0;
      for (int n = 0; n < 8; n++) step();
      qt = 0;
      n_total++;
      if (volume[3:0] !== 4'd7)
         $display("FAIL midreset_pre got %0d required 7", volume[3:0]);
      else n_pass++;
      rstn = 0; st = 4'hF; qt = 1; step();
      rstn = 1; st = 0; qt = 0;
      n_total++;
      if (volume !== 16'h0 || expired !== 4'h0)
         $display("FAIL midreset_state vol=%h exp=%b required 0000 and 0000", volume, expired);
      else n_pass++;
      qt = 1; step(); qt = 0;
      n_total++;
      if (volume[3:0] !== 4'd0 || expired[0] !== 1'b1)
         $display("FAIL midreset_no_pending vol=%0d exp=%b required 0 and 1", volume[3:0], expired[0]);
      else n_pass++;
   endtask

`ifdef ENVELOPE_ATTACK_EN
   task automatic test_attack();
      do_reset();
      at = 4'b0001; per = 16'h0000; lp = 4'b0001;
      st = 4'b0001; qt = 1; step(); st = 0;
      for (int k = 1; k <= 16; k++) begin
         step();
         n_total++;
         if (volume[3:0] !== 4'(k % 16))
            $display("FAIL attack_loop q%0d got %0d required %0d", k, volume[3:0], k % 16);
         else n_pass++;
      end
      lp = 0; st = 4'b0001; step(); st = 0;
      for (int k = 1; k <= 17; k++) begin
         step();
         n_total++;
         if (volume[3:0] !== 4'((k > 15) ? 15 : k) || expired[0] !== (k > 15))
            $display("FAIL attack_hold q%0d vol=%0d exp=%b required %0d %b",
                     k, volume[3:0], expired[0], (k > 15) ? 15 : k, (k > 15));
         else n_pass++;
      end
      qt = 0; at = 0;
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         rstn = ($urandom_range(0, 199) != 0);
         qt   = ($urandom_range(0, 2) == 0);
         for (int c = 0; c < NCH; c++) st[c] = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 15) == 0) per = 16'($urandom);
         if ($urandom_range(0, 31) == 0) lp = 4'($urandom);
         if ($urandom_range(0, 15) == 0) cv = 4'($urandom);
`ifdef ENVELOPE_ATTACK_EN
         if ($urandom_range(0, 63) == 0) at = 4'($urandom);
`endif
         step();
         for (int c = 0; c < NCH; c++) begin
            n_total++;
            if (volume[c*4 +: 4] !== exp_vol(c) || expired[c] !== m_exp[c])
               $display("FAIL random ch%0d cyc%0d vol=%0d exp=%b required vol=%0d exp=%b",
                        c, n, volume[c*4 +: 4], expired[c], exp_vol(c), m_exp[c]);
            else n_pass++;
         end
      end
      rstn = 1; st = 0; qt = 0;
   endtask

   initial begin
      rstn = 0; qt = 0; st = 0; lp = 0; cv = 0; at = 0; per = 0;
      @(posedge clk); #1;
      test_reset();
      test_oneshot();
      test_loop();
      test_const_vol();
      test_same_cycle();
      test_reset_mid();
`ifdef ENVELOPE_ATTACK_EN
      test_attack();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/envelope_bank.md
# envelope_bank

Parametrised multi-channel volume envelope generator for the APU audio path. It replaces the single-channel envelope with NCH independent channels, configurable volume and divider widths, and a registered expiry status. All channels advance on a shared quarter-frame tick from the frame sequencer. Per-channel volume feeds the channel mixers.

## Interface
- NCH, 4: number of independent envelope channels (≥1)
- VOL_W, 4: volume/decay width; MAX = 2^VOL_W − 1
- DIV_W, 4: divider period width (≥1)
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  synchronous active-low reset
- qtick  in  1  quarter-frame enable, one-cycle pulse
- start  in  NCH  per-channel restart request, one-cycle pulse
- loop  in  NCH  per-channel loop enable (level)
- constVol  in  NCH  per-channel constant-volume select (level)
- period  in  NCH*DIV_W  per-channel divider period / constant volume; channel i at [i*DIV_W +: DIV_W]
- volume  out  NCH*VOL_W  per-channel output volume; channel i at [i*VOL_W +: VOL_W]
- expired  out  NCH  channel decay reached terminal level with loop clear

## Operation
- Per-channel state: startFlag (1b), divider (DIV_W), decay (VOL_W), expired (1b).
- start[i] sets startFlag[i] at the next edge. The flag stays set until consumed by a qtick.
- On qtick, each channel independently:
  - startFlag set (or start[i] high in the same cycle): clear startFlag, decay ← MAX, divider ← period, expired ← 0.
  - else divider == 0: divider ← period, then:
    - decay ≠ 0: decay ← decay − 1
    - decay == 0 and loop: decay ← MAX
    - decay == 0 and !loop: hold at 0, expired ← 1
  - else divider ← divider − 1.
- No qtick: only startFlag capture; divider, decay and expired hold.
- Divider period is period+1 qticks. period = 0 steps decay on every qtick.
- volume[i] = constVol[i] ? period[i] resized to VOL_W (zero-extend if DIV_W < VOL_W, low bits if wider) : decay[i]. This is combinational from state and inputs.
- constVol does not stop the decay machinery; decay keeps counting underneath.
- Changing period mid-count takes effect at the next reload only.
- expired clears on restart. expired also clears on a qtick reload while loop is high.

## Timing
- Reset (rst_n low at an edge): startFlag = 0, divider = 0, decay = 0, expired = 0. volume therefore reads 0 if constVol is low, otherwise period. Reset has priority over start and qtick.
- Reset mid-decay abandons all progress. There is no pending restart after reset.
- start → restart latency: decay = MAX visible the cycle after the first qtick edge at or after start.
- Decay from MAX to 0: 15 steps × (period+1) qticks after the restart qtick.
- Multiple start pulses before a qtick merge into one restart.
- Channels never interact. Simultaneous events on different channels are independent.

## Configuration
- ENVELOPE_ATTACK_EN defined:
  - Adds input `attack` (NCH, level).
  - With attack[i] = 1, restart loads decay ← 0 and steps count up.
  - At MAX with loop set, the channel wraps to 0. At MAX without loop, it holds and asserts expired.
- ENVELOPE_ATTACK_EN undefined: the port is absent and every channel decays only.

## Structure
- Shared package envelope_pkg holds:
  - default widths (ENV_VOL_W = 4, ENV_DIV_W = 4)
  - the MAX-level function and the volume-resize function
- Sub-module envelope_channel contains one channel's state and next-state logic.
- envelope_bank instantiates NCH envelope_channel copies with a generate loop and slices the buses.

## Test plan
- Reset, then pulse start[0] with period = 3, loop = 0, and issue qticks. Required: decay = 15 after the first qtick, 14 after the 5th, 0 after the 61st, and expired[0] = 1 at the 65th qtick. Volume holds 0 thereafter.
- Same setup with loop = 1. Required: decay returns to 15 at qtick 65 and expired never asserts.
- constVol = 1, period = 9. Required: volume = 9 immediately; toggling constVol to 0 shows the running decay value.
- start and qtick in the same cycle on channel 1, with a start-only pulse on channel 2 and no qtick. Required: channel 1 is at 15 next cycle. Channel 2 stays unchanged until the next qtick, then shows 15.
- Drive rst_n low mid-decay (decay = 7) together with start high. Required: all state is 0 next cycle and no restart is pending.
- With ENVELOPE_ATTACK_EN and attack = 1, period = 0. Required: 0, 1, …, 15 on successive qticks; wraps to 0 with loop = 1, and holds at 15 with expired = 1 when loop = 0.
